// File: rtl/conv3x3_tile_ctrl_pkg.sv
// Shared types and constants for the 3x3 convolution tile sequencer.
// The window tap helper writes one 8-bit pixel into the packed 72-bit window.
package conv_ctrl_pkg;
  localparam int PIX_W    = 8;
  localparam int WIN_TAPS = 9;
  localparam int RES_W    = 16;
  localparam int WIN_W    = PIX_W * WIN_TAPS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_CONV,
    ST_OUT,
    ST_DONE
  } state_t;

  function automatic logic [WIN_W-1:0] set_tap(input logic [WIN_W-1:0] win,
                                               input logic [3:0]       k,
                                               input logic [PIX_W-1:0] pix);
    logic [WIN_W-1:0] w;
    w = win;
    for (int i = 0; i < WIN_TAPS; i++) begin
      if (k == 4'(i)) w[i*PIX_W +: PIX_W] = pix;
    end
    return w;
  endfunction
endpackage

// File: rtl/conv3x3_tile_ctrl_if.sv
// Result stream port of the tile sequencer (valid/ready with output coordinate).
// master drives results, slave accepts them.
interface conv3x3_tile_ctrl_if;
  import conv_ctrl_pkg::*;

  logic             res_valid;
  logic             res_ready;
  logic [RES_W-1:0] res_data;
  logic [7:0]       res_row;
  logic [7:0]       res_col;

  modport master (output res_valid, output res_data, output res_row, output res_col,
                  input res_ready);
  modport slave  (input res_valid, input res_data, input res_row, input res_col,
                  output res_ready);
endinterface

// File: rtl/conv3x3_addr_gen.sv
// Combinational image RAM address for tap k of the window anchored at (row, col).
module conv3x3_addr_gen
  import conv_ctrl_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int ADDR_W = 8
) (
  input  logic [7:0]        row,
  input  logic [7:0]        col,
  input  logic [3:0]        k,
  output logic [ADDR_W-1:0] addr
);
  logic [3:0] tap_r;
  logic [3:0] tap_c;

  assign tap_r = k / 4'd3;
  assign tap_c = k % 4'd3;
  assign addr  = ADDR_W'((32'(row) + 32'(tap_r)) * 32'(IMG_W) + 32'(col) + 32'(tap_c));
endmodule

// File: rtl/conv3x3_tile_ctrl.sv
// 3x3 convolution tile sequencer: fetches each valid window, drives the external
// conv unit and streams results. Optional ReLU clamp on the result: CONV_CTRL_RELU_EN.
module conv3x3_tile_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                filter_load,
  input  logic [WIN_W-1:0]    filter_in,
  output logic                busy,
  output logic                done,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [PIX_W-1:0]    mem_rd_data,
  output logic [WIN_W-1:0]    conv_filter,
  output logic [WIN_W-1:0]    conv_img,
  input  logic [RES_W-1:0]    conv_result,
  conv3x3_tile_ctrl_if.master res
);
  // state | meaning
  // IDLE  | wait for start; filter_load latches the filter
  // FETCH | issue reads for taps 0..8, capture tap k-1
  // WAIT  | capture tap 8, window now complete
  // CONV  | register conv unit result and its coordinate
  // OUT   | hold result until accepted, then advance position
  // DONE  | one-cycle done pulse
  state_t            state;
  logic [7:0]        row, col;
  logic [3:0]        k;
  logic [7:0]        nxt_row, nxt_col;
  logic [3:0]        nxt_k;
  logic [ADDR_W-1:0] nxt_addr;
  logic              last_pos;
  logic [RES_W-1:0]  res_post;

  assign last_pos = (row == 8'(IMG_H - 3)) && (col == 8'(IMG_W - 3));

  // Position/tap that the next registered mem_addr belongs to.
  always_comb begin
    nxt_row = row;
    nxt_col = col;
    nxt_k   = k + 4'd1;
    case (state)
      ST_IDLE: begin
        nxt_row = '0;
        nxt_col = '0;
        nxt_k   = '0;
      end
      ST_OUT: begin
        nxt_k = '0;
        if (col == 8'(IMG_W - 3)) begin
          nxt_col = '0;
          nxt_row = row + 8'd1;
        end else begin
          nxt_col = col + 8'd1;
        end
      end
      default: ;
    endcase
  end

  conv3x3_addr_gen #(.IMG_W(IMG_W), .ADDR_W(ADDR_W)) u_addr_gen (
    .row  (nxt_row),
    .col  (nxt_col),
    .k    (nxt_k),
    .addr (nxt_addr)
  );

  always_comb begin
`ifdef CONV_CTRL_RELU_EN
    res_post = conv_result[RES_W-1] ? '0 : conv_result;
`else
    res_post = conv_result;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      row           <= '0;
      col           <= '0;
      k             <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem_rd_en     <= 1'b0;
      mem_addr      <= '0;
      conv_filter   <= '0;
      conv_img      <= '0;
      res.res_valid <= 1'b0;
      res.res_data  <= '0;
      res.res_row   <= '0;
      res.res_col   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (filter_load) conv_filter <= filter_in;
          if (start) begin
            row       <= nxt_row;
            col       <= nxt_col;
            k         <= nxt_k;
            mem_rd_en <= 1'b1;
            mem_addr  <= nxt_addr;
            busy      <= 1'b1;
            state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (k != 4'd0) conv_img <= set_tap(conv_img, k - 4'd1, mem_rd_data);
          if (k == 4'd8) begin
            mem_rd_en <= 1'b0;
            state     <= ST_WAIT;
          end else begin
            k        <= nxt_k;
            mem_addr <= nxt_addr;
          end
        end
        ST_WAIT: begin
          conv_img <= set_tap(conv_img, 4'd8, mem_rd_data);
          state    <= ST_CONV;
        end
        ST_CONV: begin
          res.res_data  <= res_post;
          res.res_row   <= row;
          res.res_col   <= col;
          res.res_valid <= 1'b1;
          state         <= ST_OUT;
        end
        ST_OUT: begin
          if (res.res_ready) begin
            res.res_valid <= 1'b0;
            if (last_pos) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              row       <= nxt_row;
              col       <= nxt_col;
              k         <= nxt_k;
              mem_rd_en <= 1'b1;
              mem_addr  <= nxt_addr;
              state     <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv3x3_tile_ctrl.sv
// Bench for conv3x3_tile_ctrl on a 5x5 tile: directed timing/stall/reset/ReLU steps
// plus randomized image, filter and backpressure checked against a window-sum model.
module tb_conv3x3_tile_ctrl;
  localparam int W = 5;
  localparam int H = 5;

  logic        clk;
  logic        rst;
  logic        start;
  logic        filter_load;
  logic [71:0] filter_in;
  logic        busy;
  logic        done;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rd_data;
  logic [71:0] conv_filter;
  logic [71:0] conv_img;
  logic [15:0] conv_result;
  logic        conv_force;

  conv3x3_tile_ctrl_if rif ();

  conv3x3_tile_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .filter_load (filter_load),
    .filter_in   (filter_in),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .conv_filter (conv_filter),
    .conv_img    (conv_img),
    .conv_result (conv_result),
    .res         (rif)
  );

  logic [7:0] ram [0:255];
  logic [7:0] filt [0:8];

  int checks   = 0;
  int failures = 0;
  int done_cnt;
  logic [15:0] got_data[$];
  logic [7:0]  got_row[$];
  logic [7:0]  got_col[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_addr];

  // External conv unit: sum of products over the packed window and filter.
  always_comb begin
    conv_result = 16'd0;
    if (conv_force) conv_result = 16'hFFF6;
    else
      for (int i = 0; i < 9; i++)
        conv_result = conv_result + 16'(conv_img[8*i +: 8]) * 16'(conv_filter[8*i +: 8]);
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef CONV_CTRL_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  // Reference: output (r,c) is the dot product of the image window at (r,c) with the filter.
  function automatic logic [15:0] exp_res(input int r, input int c);
    int s;
    s = 0;
    for (int kr = 0; kr < 3; kr++)
      for (int kc = 0; kc < 3; kc++)
        s += int'(ram[(r + kr) * W + c + kc]) * int'(filt[3 * kr + kc]);
    return relu(16'(s));
  endfunction

  function automatic logic [71:0] pack_filt();
    logic [71:0] f;
    for (int i = 0; i < 9; i++) f[8*i +: 8] = filt[i];
    return f;
  endfunction

  task automatic load_filter();
    filter_in   = pack_filt();
    filter_load = 1'b1;
    @(negedge clk);
    filter_load = 1'b0;
    chk("filter_loaded", conv_filter, pack_filt());
  endtask

  task automatic run_pass(input bit rand_ready, input bit timing_chk, input bit stall_chk,
                          input bit inject);
    int j;
    int stall_cnt;
    bit finished;
    logic [71:0] exp_win;
    int exp_addr [9];
    exp_addr = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    for (int kk = 0; kk < 9; kk++) exp_win[8*kk +: 8] = ram[(kk / 3) * W + 1 + kk % 3];
    got_data.delete();
    got_row.delete();
    got_col.delete();
    done_cnt  = 0;
    stall_cnt = 0;
    finished  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    j = 1;
    while (!finished && j <= 2000) begin
      if (j == 1) chk("busy_after_start", 72'(busy), 72'(1));
      if (timing_chk) begin
        if (j <= 9) begin
          chk($sformatf("rd_en_c%0d", j), 72'(mem_rd_en), 72'(1));
          chk($sformatf("addr_c%0d", j), 72'(mem_addr), 72'(exp_addr[j-1]));
        end
        if (j == 10) chk("rd_en_wait", 72'(mem_rd_en), 72'(0));
        if (j == 11) chk("valid_c11", 72'(rif.res_valid), 72'(0));
        if (j == 12) chk("valid_c12", 72'(rif.res_valid), 72'(1));
      end
      if (done) begin
        done_cnt++;
        finished    = 1'b1;
        start       = 1'b0;
        filter_load = 1'b0;
      end else if (inject) begin
        start       = ($urandom_range(0, 3) == 0);
        filter_load = ($urandom_range(0, 3) == 0);
        filter_in   = 72'({$urandom, $urandom, $urandom});
      end
      if (stall_chk && rif.res_valid && got_data.size() == 1 && stall_cnt < 20) begin
        rif.res_ready = 1'b0;
        stall_cnt++;
        chk("stall_valid", 72'(rif.res_valid), 72'(1));
        chk("stall_data", 72'(rif.res_data), 72'(63));
        chk("stall_col", 72'(rif.res_col), 72'(1));
        chk("stall_rd_en", 72'(mem_rd_en), 72'(0));
        chk("stall_addr", 72'(mem_addr), 72'(13));
        chk("stall_img", conv_img, exp_win);
      end else begin
        rif.res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (rif.res_valid && rif.res_ready) begin
        got_data.push_back(rif.res_data);
        got_row.push_back(rif.res_row);
        got_col.push_back(rif.res_col);
      end
      @(negedge clk);
      j++;
    end
    start         = 1'b0;
    filter_load   = 1'b0;
    rif.res_ready = 1'b1;
    chk("pass_finished", 72'(finished), 72'(1));
    if (stall_chk) chk("stall_cycles", 72'(stall_cnt), 72'(20));
    chk("idle_busy", 72'(busy), 72'(0));
    chk("idle_done", 72'(done), 72'(0));
    chk("done_count", 72'(done_cnt), 72'(1));
  endtask

  task automatic check_results(input string tag);
    chk({tag, "_count"}, 72'(got_data.size()), 72'(9));
    for (int i = 0; i < 9 && i < got_data.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), 72'(got_data[i]), 72'(exp_res(i / 3, i % 3)));
      chk($sformatf("%s_row%0d", tag, i), 72'(got_row[i]), 72'(i / 3));
      chk($sformatf("%s_col%0d", tag, i), 72'(got_col[i]), 72'(i % 3));
    end
  endtask

  initial begin
    int hs;
    int cyc;
    logic [15:0] neg_exp;
    rst           = 1'b1;
    start         = 1'b0;
    filter_load   = 1'b0;
    filter_in     = '0;
    conv_force    = 1'b0;
    rif.res_ready = 1'b1;
    for (int a = 0; a < 256; a++) ram[a] = 8'(a);
    for (int i = 0; i < 9; i++) filt[i] = 8'h01;
    @(negedge clk);
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_done", 72'(done), 72'(0));
    chk("rst_rd_en", 72'(mem_rd_en), 72'(0));
    chk("rst_addr", 72'(mem_addr), 72'(0));
    chk("rst_valid", 72'(rif.res_valid), 72'(0));
    chk("rst_data", 72'(rif.res_data), 72'(0));
    chk("rst_row", 72'(rif.res_row), 72'(0));
    chk("rst_col", 72'(rif.res_col), 72'(0));
    chk("rst_img", conv_img, 72'(0));
    chk("rst_filter", conv_filter, 72'(0));
    rst = 1'b0;
    @(negedge clk);

    load_filter();
    run_pass(1'b0, 1'b1, 1'b0, 1'b0);
    check_results("ramp");
    chk("ramp_first", 72'(got_data.size() > 0 ? got_data[0] : 16'hDEAD), 72'(54));
    chk("ramp_last", 72'(got_data.size() > 8 ? got_data[8] : 16'hDEAD), 72'(162));

    run_pass(1'b0, 1'b0, 1'b1, 1'b0);
    check_results("stall");

    // Abort during the fourth window's fetch, then restart.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hs = 0;
    cyc = 0;
    while (hs < 3 && cyc < 200) begin
      if (rif.res_valid) hs++;
      if (hs < 3) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("abort_hs", 72'(hs), 72'(3));
    repeat (3) @(negedge clk);
    chk("abort_in_fetch", 72'(mem_rd_en), 72'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 72'(busy), 72'(0));
    chk("abort_valid", 72'(rif.res_valid), 72'(0));
    chk("abort_rd_en", 72'(mem_rd_en), 72'(0));
    chk("abort_filter", conv_filter, 72'(0));
    chk("abort_img", conv_img, 72'(0));
    load_filter();
    run_pass(1'b0, 1'b0, 1'b0, 1'b0);
    check_results("restart");
    chk("restart_first", 72'(got_data.size() > 0 ? got_data[0] : 16'hDEAD), 72'(54));

`ifdef CONV_CTRL_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'hFFF6;
`endif
    conv_force = 1'b1;
    run_pass(1'b0, 1'b0, 1'b0, 1'b0);
    conv_force = 1'b0;
    chk("neg_count", 72'(got_data.size()), 72'(9));
    chk("neg_first", 72'(got_data.size() > 0 ? got_data[0] : 16'hDEAD), 72'(neg_exp));
    chk("neg_last", 72'(got_data.size() > 8 ? got_data[8] : 16'hDEAD), 72'(neg_exp));

    for (int it = 0; it < 3; it++) begin
      for (int a = 0; a < W * H; a++) ram[a] = 8'($urandom_range(0, 15));
      for (int i = 0; i < 9; i++) filt[i] = 8'($urandom_range(0, 15));
      load_filter();
      run_pass(1'b1, 1'b0, 1'b0, 1'b1);
      check_results($sformatf("rand%0d", it));
      chk($sformatf("rand%0d_filter_kept", it), conv_filter, pack_filt());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv3x3_tile_ctrl.md
# conv3x3_tile_ctrl

Sequencer that owns the 3x3 convolution datapath for one feature-map tile. It walks every valid (unpadded) output position of an IMG_H x IMG_W 8-bit tile in row-major order and fetches the nine window pixels from a 1-cycle-latency image RAM. It presents the packed 72-bit window and the stored 72-bit filter to the external combinational conv3x3 unit, registers its 16-bit result, and streams results out through a valid/ready port. It sits between the tile buffer and the layer output writer.

## Interface
- IMG_W, 16, tile width in pixels (>= 3)
- IMG_H, 16, tile height in pixels (>= 3)
- ADDR_W, 8, image RAM address width; IMG_W*IMG_H <= 2**ADDR_W
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin one tile pass; sampled only in IDLE
- filter_load  in  1  latch filter_in into filter register; sampled only in IDLE
- filter_in  in  72  nine 8-bit coefficients, coefficient k at [8k+7:8k], k = 3*r + c
- busy  out  1  high from the cycle after start is accepted until the DONE cycle, inclusive
- done  out  1  one-cycle pulse after the last result handshake
- mem_rd_en  out  1  image RAM read strobe
- mem_addr  out  ADDR_W  image RAM address
- mem_rd_data  in  8  read data, valid the cycle after mem_rd_en
- conv_filter  out  72  filter register, to conv unit
- conv_img  out  72  window register, same packing as filter_in
- conv_result  in  16  combinational conv unit output
- res_valid  out  1  result available
- res_ready  in  1  downstream accept
- res_data  out  16  registered result
- res_row, res_col  out  8 each  output coordinate of res_data

## Operation
- States: IDLE, FETCH, WAIT, CONV, OUT, DONE.
- IDLE: filter_load=1 loads the filter register. start=1 clears row/col/k and goes to FETCH. If both are asserted in the same cycle, the load completes first and start is still accepted.
- FETCH: 9 cycles, k = 0..8. mem_rd_en=1 and mem_addr = (row + k/3)*IMG_W + col + k%3. Data for k-1 is written into window slot k-1. Then go to WAIT.
- WAIT: 1 cycle; slot 8 is written; mem_rd_en=0.
- CONV: 1 cycle; res_data <= conv_result (post-processed per Configuration); res_row/res_col are latched.
- OUT: res_valid=1 until res_ready=1. On the handshake, advance col; wrap to 0 and increment row at col = IMG_W-3. Go to FETCH, or to DONE after position (IMG_H-3, IMG_W-3).
- DONE: done=1 for one cycle, then IDLE.
- Output grid is (IMG_H-2) x (IMG_W-2). Results are emitted strictly in row-major order.
- start and filter_load outside IDLE are ignored, including in the DONE cycle.
- The window register holds its contents between windows. It is fully rewritten before each CONV.

## Timing
- Reset values: busy 0, done 0, mem_rd_en 0, mem_addr 0, res_valid 0, res_data 0, res_row 0, res_col 0, conv_img 0, conv_filter 0. State is IDLE.
- rst mid-pass aborts immediately: next cycle is IDLE with all reset values. The filter register is also cleared.
- With start sampled at edge t: reads occur in cycles t+1..t+9, and res_valid first rises in cycle t+12.
- Per-window cost with res_ready held high is 12 cycles (9 FETCH, 1 WAIT, 1 CONV, 1 OUT).
- Stall: while res_valid=1 and res_ready=0, res_data, res_row, res_col, conv_img and mem_addr hold, and mem_rd_en=0.
- conv_result must settle within one cycle of conv_img becoming stable (end of WAIT).

## Configuration
- CONV_CTRL_RELU_EN defined: conv_result is treated as signed, and negative values are registered as 16'h0000.
- CONV_CTRL_RELU_EN undefined: conv_result is registered unchanged.

## Structure
- Package conv_ctrl_pkg holds:
  - state enum
  - PIX_W=8, WIN_TAPS=9, RES_W=16
  - tap-slot packing helper
- Sub-module conv3x3_addr_gen: combinational (row, col, k) -> mem_addr, parameterized by IMG_W and ADDR_W.
- The conv3x3 unit itself is external to this block.

## Test plan
- IMG_W=IMG_H=5, RAM[a]=a, filter all 8'h01, sum-of-products conv model, res_ready=1. Required response:
  - 9 results in order, result(r,c) = 9*(5r+c)+54: first 54, last 162
  - done pulses once
- Same setup, start at edge t: mem_addr = 0,1,2,5,6,7,10,11,12 in cycles t+1..t+9, and res_valid rises in cycle t+12.
- Hold res_ready low 20 cycles on the second result (value 63): res_valid, res_data=63 and res_col=1 stay stable, and mem_rd_en stays 0.
- Assert rst during the 4th window's FETCH, then start again: the bench sees busy=0 and res_valid=0 the next cycle. The restarted pass first emits (0,0)=54.
- Conv model forced to 16'hFFF6: res_data=16'h0000 with CONV_CTRL_RELU_EN, 16'hFFF6 without.
- start and filter_load pulsed while busy: the result sequence and conv_filter are unchanged.
